// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: RUN / IC_WAIT / FLUSH sequencing of PC, IF/ID and back-end write enables.
// Optional perf counters built only when HAZARD_PERF_CNT_EN is defined.
module hazard_stall_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             LOAD_USE_STALL,
    input  logic             BRANCH_TAKEN,
    input  logic             IC_MISS,
    input  logic             IC_FILL_DONE,
    output logic             PC_WE,
    output logic             IF_ID_WE,
    output logic             PIPE_WE,
    output logic             IF_ID_FLUSH,
    output logic             ID_EX_FLUSH,
    output logic [1:0]       STATE,
    output logic [CNT_W-1:0] STALL_CNT,
    output logic [CNT_W-1:0] FLUSH_CNT
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_IC_WAIT = 2'b01,
        ST_FLUSH   = 2'b10,
        ST_BAD     = 2'b11
    } state_e;

    localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES - 1);

    state_e     state_q, state_d;
    state_e     ret_q, ret_d;
    logic [1:0] fcnt_q, fcnt_d;

    always_comb begin
        state_d     = state_q;
        ret_d       = ret_q;
        fcnt_d      = fcnt_q;
        PC_WE       = 1'b0;
        IF_ID_WE    = 1'b0;
        PIPE_WE     = 1'b0;
        IF_ID_FLUSH = 1'b0;
        ID_EX_FLUSH = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (BRANCH_TAKEN) begin
                    PC_WE       = 1'b1;
                    IF_ID_WE    = 1'b1;
                    PIPE_WE     = 1'b1;
                    IF_ID_FLUSH = 1'b1;
                    ID_EX_FLUSH = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = ST_FLUSH;
                        fcnt_d  = FLUSH_INIT;
                    end else begin
                        fcnt_d  = 2'd0;
                    end
                end else if (IC_MISS) begin
                    state_d = ST_IC_WAIT;
                    ret_d   = ST_RUN;
                end else if (LOAD_USE_STALL) begin
                    // Hold PC and IF/ID, let the back end advance with a bubble.
                    PIPE_WE     = 1'b1;
                    ID_EX_FLUSH = 1'b1;
                end else begin
                    PC_WE    = 1'b1;
                    IF_ID_WE = 1'b1;
                    PIPE_WE  = 1'b1;
                end
            end
            ST_IC_WAIT: begin
                if (IC_FILL_DONE) begin
                    state_d = ret_q;
                end
            end
            ST_FLUSH: begin
                if (IC_MISS) begin
                    state_d = ST_IC_WAIT;
                    ret_d   = ST_FLUSH;
                end else begin
                    PC_WE       = 1'b1;
                    IF_ID_WE    = 1'b1;
                    PIPE_WE     = 1'b1;
                    IF_ID_FLUSH = 1'b1;
                    fcnt_d      = fcnt_q - 2'd1;
                    if (fcnt_q <= 2'd1) begin
                        state_d = ST_RUN;
                        fcnt_d  = 2'd0;
                    end
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (RST) begin
            PC_WE       = 1'b0;
            IF_ID_WE    = 1'b0;
            PIPE_WE     = 1'b0;
            IF_ID_FLUSH = 1'b1;
            ID_EX_FLUSH = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_RUN;
            ret_q   <= ST_RUN;
            fcnt_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign STATE = state_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!PC_WE && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (IF_ID_FLUSH && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign STALL_CNT = stall_cnt_q;
    assign FLUSH_CNT = flush_cnt_q;
`else
    assign STALL_CNT = '0;
    assign FLUSH_CNT = '0;
`endif

endmodule

// File: doc/hazard_stall_ctrl.md
HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 1, legal 1..3: cycles IF_ID_FLUSH is held per taken branch/jump.
REQ-002 SHALL have parameter CNT_W, default 32: perf counter width.
REQ-003 SHALL have port CLK  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port LOAD_USE_STALL  input  1  load-use stall request from forwarding unit.
REQ-006 SHALL have port BRANCH_TAKEN  input  1  EX-stage redirect (branch taken/JAL/JALR).
REQ-007 SHALL have port IC_MISS  input  1  instruction cache miss on current fetch.
REQ-008 SHALL have port IC_FILL_DONE  input  1  one-cycle pulse, cache line fill complete.
REQ-009 SHALL have ports PC_WE, IF_ID_WE, PIPE_WE  output  1 each  enables for PC, IF/ID, and ID/EX+EX/MEM+MEM/WB registers.
REQ-010 SHALL have ports IF_ID_FLUSH, ID_EX_FLUSH  output  1 each  insert bubble (NOP) into that register on the next edge.
REQ-011 SHALL have port STATE  output  2  current FSM state (RUN=00, IC_WAIT=01, FLUSH=10).
REQ-012 SHALL have ports STALL_CNT, FLUSH_CNT  output  CNT_W each  perf counters (see Configuration).

Function
REQ-013 SHALL implement FSM RUN/IC_WAIT/FLUSH; state registered, outputs combinational from state and inputs.
REQ-014 RUN priority SHALL be BRANCH_TAKEN > IC_MISS > LOAD_USE_STALL > normal.
REQ-015 RUN+BRANCH_TAKEN: PC_WE=1, PIPE_WE=1, IF_ID_WE=1, IF_ID_FLUSH=1, ID_EX_FLUSH=1; next FLUSH with count FLUSH_CYCLES-1 if FLUSH_CYCLES>1, else RUN; same-cycle IC_MISS/LOAD_USE_STALL ignored.
REQ-016 RUN+IC_MISS (no branch): all WE=0, flushes 0; next IC_WAIT, return state RUN.
REQ-017 RUN+LOAD_USE_STALL only: PC_WE=0, IF_ID_WE=0, PIPE_WE=1, ID_EX_FLUSH=1, IF_ID_FLUSH=0; exactly one bubble per asserted cycle.
REQ-018 RUN, no request: PC_WE=IF_ID_WE=PIPE_WE=1, flushes 0.
REQ-019 IC_WAIT: all WE=0, flushes 0, every cycle including the IC_FILL_DONE cycle; all other inputs ignored.
REQ-020 IC_WAIT+IC_FILL_DONE: next state = saved return state (RUN or FLUSH), flush count preserved.
REQ-021 FLUSH: PC_WE=IF_ID_WE=PIPE_WE=1, IF_ID_FLUSH=1, ID_EX_FLUSH=0; count decrements; next RUN when count reaches 0.
REQ-022 FLUSH+IC_MISS: all WE=0, IF_ID_FLUSH=0, count held; next IC_WAIT, return state FLUSH.
REQ-023 FLUSH SHALL ignore BRANCH_TAKEN and LOAD_USE_STALL (wrong-path only).
REQ-024 IC_FILL_DONE outside IC_WAIT SHALL be ignored.
REQ-025 STATE value 11 SHALL be unreachable; if entered, next state RUN.

Reset
REQ-026 RST high at rising edge: next state RUN, flush count 0, return state RUN, counters 0.
REQ-027 While RST high: PC_WE=IF_ID_WE=PIPE_WE=0, IF_ID_FLUSH=ID_EX_FLUSH=1, regardless of state or inputs.
REQ-028 RST mid-IC_WAIT or mid-FLUSH SHALL abandon the operation; first cycle after RST deasserts is RUN with no pending flush.

Configuration
REQ-029 Macro HAZARD_PERF_CNT_EN defined: STALL_CNT +1 per cycle with PC_WE=0 and RST low; FLUSH_CNT +1 per cycle with IF_ID_FLUSH=1 and RST low; both saturate at all-ones.
REQ-030 Macro not defined: STALL_CNT and FLUSH_CNT tied to 0, no counter registers synthesized; all other behaviour identical.

Verification
REQ-031 RUN, LOAD_USE_STALL=1 one cycle -> that cycle PC_WE=0, IF_ID_WE=0, ID_EX_FLUSH=1, PIPE_WE=1; next cycle all WE=1, STATE=00.
REQ-032 FLUSH_CYCLES=3, BRANCH_TAKEN one cycle -> IF_ID_FLUSH=1 for 3 consecutive cycles, ID_EX_FLUSH=1 first cycle only, STATE 00,10,10,00.
REQ-033 IC_MISS=1, IC_FILL_DONE 5 cycles later -> all WE=0 for 6 cycles, STATE=01 for 5 cycles, WE=1 on 7th; STALL_CNT=6 (macro on).
REQ-034 BRANCH_TAKEN, IC_MISS, LOAD_USE_STALL same cycle -> branch response only (REQ-015), STATE never 01.
REQ-035 FLUSH_CYCLES=2, IC_MISS during FLUSH, fill after 3 cycles -> returns to FLUSH, one remaining IF_ID_FLUSH cycle, then RUN; FLUSH_CNT=2.
REQ-036 RST asserted in IC_WAIT -> outputs per REQ-027 that cycle; next cycle STATE=00, counters 0, PC_WE=1 with no request.
